// File: rtl/i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter
//   Shares one single-register I2C write/read engine (i2c_diver) among NUM_REQ
//   requesters with round-robin fairness. Each transaction is sequenced through
//   the engine's wt_req/rd_req -> busy -> success handshake, and the outcome
//   (done/err, plus the read byte) is returned to the granted requester.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_rd      per-requester request level and direction (1=read)
//   req_sla/sub/wdata     per-requester bytes, requester i at [8i+:8]
//   grant                 one-hot owner, high from ISSUE until done/err
//   done/err              one-cycle per-requester completion pulses
//   rdata                 read byte, valid in the cycle done pulses for a read
//   drv_*  (out)          address/data/request toward the engine
//   drv_data_r/busy/success (in) engine read byte, busy, success level
// -----------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rd,
    input  logic [8*NUM_REQ-1:0] req_sla,
    input  logic [8*NUM_REQ-1:0] req_sub,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic [7:0]           rdata,
    output logic [7:0]           drv_sla_addr,
    output logic [7:0]           drv_sub_addr,
    output logic [7:0]           drv_data_w,
    output logic                 drv_wt_req,
    output logic                 drv_rd_req,
    input  logic [7:0]           drv_data_r,
    input  logic                 drv_busy,
    input  logic                 drv_success
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    own_q, own_d;
    logic                rd_q, rd_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                succ_prev_q;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [7:0]          sla_q, sla_d;
    logic [7:0]          sub_q, sub_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                wt_req_q, wt_req_d;
    logic                rd_req_q, rd_req_d;

    // Round-robin pick result
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_rd;
    logic [7:0]          pick_sla, pick_sub, pick_wdata;

    logic                success;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // The engine's success is a level that may stay high across operations;
    // only its rising edge marks completion of the current transaction.
    assign success = drv_success & ~succ_prev_q;

    // First valid requester searching upward from the rr pointer, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_rd    = 1'b0;
        pick_sla   = '0;
        pick_sub   = '0;
        pick_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin : g_search
            int c;
            c = int'(rr_q) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!pick_found && req_valid[c]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(c);
                pick_rd    = req_rd[c];
                pick_sla   = req_sla[8*c +: 8];
                pick_sub   = req_sub[8*c +: 8];
                pick_wdata = req_wdata[8*c +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        own_d    = own_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_d   = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        sla_d    = sla_q;
        sub_d    = sub_q;
        wdata_d  = wdata_q;
        wt_req_d = wt_req_q;
        rd_req_d = rd_req_q;

        case (state_q)
            S_IDLE: begin
                // A busy engine here belongs to someone else; leave it alone.
                if (!drv_busy && pick_found) begin
                    own_d    = pick_idx;
                    rd_d     = pick_rd;
                    sla_d    = pick_sla;
                    sub_d    = pick_sub;
                    wdata_d  = pick_wdata;
                    grant_d  = onehot(pick_idx);
                    // Request goes high as ISSUE begins and is held until busy.
                    wt_req_d = ~pick_rd;
                    rd_req_d = pick_rd;
                    cnt_d    = '0;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: state_d = S_WAIT_BUSY;

            S_WAIT_BUSY: begin
                if (drv_busy) begin
                    wt_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    wt_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    err_d    = onehot(own_q);
                    state_d  = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_DONE: begin
                // Success has priority over both busy-drop and timeout.
                if (success) begin
                    done_d = onehot(own_q);
                    if (rd_q) rdata_d = drv_data_r;
                    state_d = S_RELEASE;
                end else if (!drv_busy || cnt_q == TO_LAST) begin
                    err_d   = onehot(own_q);
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                grant_d = '0;
                rr_d    = (own_q == IDX_LAST) ? '0 : own_q + 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            own_q       <= '0;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            succ_prev_q <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            sla_q       <= '0;
            sub_q       <= '0;
            wdata_q     <= '0;
            wt_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            own_q       <= own_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            succ_prev_q <= drv_success;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            sla_q       <= sla_d;
            sub_q       <= sub_d;
            wdata_q     <= wdata_d;
            wt_req_q    <= wt_req_d;
            rd_req_q    <= rd_req_d;
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign drv_sla_addr = sla_q;
    assign drv_sub_addr = sub_q;
    assign drv_data_w   = wdata_q;
    assign drv_wt_req   = wt_req_q;
    assign drv_rd_req   = rd_req_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_bus_arbiter
//   Directed bench for i2c_bus_arbiter with two requesters and a short timeout.
//   The engine side is played by the bench. Inputs change and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

    localparam int NR = 2;
    localparam int TO = 16;
    localparam int TW = 5;

    logic            clk, rst_n;
    logic [NR-1:0]   req_valid, req_rd;
    logic [8*NR-1:0] req_sla, req_sub, req_wdata;
    logic [NR-1:0]   grant, done, err;
    logic [7:0]      rdata, drv_sla_addr, drv_sub_addr, drv_data_w, drv_data_r;
    logic            drv_wt_req, drv_rd_req, drv_busy, drv_success;

    int errors = 0;
    int checks = 0;

    i2c_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO), .TO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rd(req_rd),
        .req_sla(req_sla), .req_sub(req_sub), .req_wdata(req_wdata),
        .grant(grant), .done(done), .err(err), .rdata(rdata),
        .drv_sla_addr(drv_sla_addr), .drv_sub_addr(drv_sub_addr),
        .drv_data_w(drv_data_w), .drv_wt_req(drv_wt_req), .drv_rd_req(drv_rd_req),
        .drv_data_r(drv_data_r), .drv_busy(drv_busy), .drv_success(drv_success)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Engine model: wait for a request (bounded), raise busy after lat cycles,
    // then either pulse success with dr or drop busy. Returns at the falling
    // edge where the arbiter's done/err pulse is visible.
    task automatic drv_serve(input int lat, input bit ok, input logic [7:0] dr,
                             output bit seen, output logic [NR-1:0] g,
                             output logic was_rd);
        seen = 1'b0; g = '0; was_rd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (drv_wt_req || drv_rd_req) begin
                seen = 1'b1; g = grant; was_rd = drv_rd_req;
                break;
            end
        end
        if (seen) begin
            repeat (lat) @(negedge clk);
            drv_busy = 1'b1;
            repeat (2) @(negedge clk);
            if (ok) begin
                drv_data_r  = dr;
                drv_success = 1'b1;
            end else begin
                drv_data_r = dr;
                drv_busy   = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic drv_idle();
        drv_success = 1'b0;
        drv_busy    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_rd = '0; req_sla = '0; req_sub = '0;
        req_wdata = '0; drv_data_r = '0; drv_busy = 1'b0; drv_success = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if ({done, err} !== 4'b0) begin errors++; $display("FAIL reset_done_err got=%b exp=0000", {done, err}); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if ({drv_sla_addr, drv_sub_addr, drv_data_w} !== 24'h0) begin errors++;
            $display("FAIL reset_drv_regs got=%h exp=000000", {drv_sla_addr, drv_sub_addr, drv_data_w}); end
        checks++; if ({drv_wt_req, drv_rd_req} !== 2'b00) begin errors++; $display("FAIL reset_drv_req got=%b exp=00", {drv_wt_req, drv_rd_req}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        bit seen;
        req_sla[7:0] = 8'h72; req_sub[7:0] = 8'h15; req_wdata[7:0] = 8'h00;
        req_rd[0] = 1'b0; req_valid = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (drv_wt_req) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL wr_issue got=0 exp=1 (no wt_req)"); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wr_grant got=%b exp=01", grant); end
        checks++; if ({drv_sla_addr, drv_sub_addr, drv_data_w} !== 24'h721500) begin errors++;
            $display("FAIL wr_drv_regs got=%h exp=721500", {drv_sla_addr, drv_sub_addr, drv_data_w}); end
        checks++; if (drv_rd_req !== 1'b0) begin errors++; $display("FAIL wr_rd_req got=%b exp=0", drv_rd_req); end
        // Disturb the request while granted: must be ignored.
        req_sla[7:0] = 8'h11; req_valid = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (drv_wt_req !== 1'b1) begin errors++; $display("FAIL wr_req_held got=%b exp=1", drv_wt_req); end
        drv_busy = 1'b1;
        @(negedge clk);
        checks++; if (drv_wt_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop got=%b exp=0", drv_wt_req); end
        checks++; if (drv_sla_addr !== 8'h72) begin errors++; $display("FAIL wr_sla_stable got=%h exp=72", drv_sla_addr); end
        @(negedge clk);
        drv_data_r = 8'h5A; drv_success = 1'b1;
        @(negedge clk);
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL wr_done got=%b exp=01", done); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL wr_err got=%b exp=00", err); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata got=%h exp=00", rdata); end
        drv_idle();
        @(negedge clk);
        checks++; if ({grant, done} !== 4'b0) begin errors++; $display("FAIL wr_release got=%b exp=0000", {grant, done}); end
    endtask

    task automatic test_round_robin();
        bit seen; logic [NR-1:0] g; logic r;
        logic [NR-1:0] exp_g;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_sla = 16'h7272; req_sub = 16'h0102; req_wdata = 16'hA0B0;
        req_rd = 2'b00; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            drv_serve(2, 1'b1, 8'h00, seen, g, r);
            checks++; if (g !== exp_g || !seen) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, g, exp_g); end
            checks++; if (done !== exp_g) begin errors++; $display("FAIL rr_done_%0d got=%b exp=%b", i, done, exp_g); end
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_overlap_%0d got=%b exp=%b", i, grant, exp_g); end
            drv_idle();
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        bit seen; logic [NR-1:0] g; logic r;
        req_sla[15:8] = 8'h72; req_sub[15:8] = 8'h42; req_rd = 2'b10; req_valid = 2'b10;
        drv_serve(1, 1'b1, 8'h60, seen, g, r);
        checks++; if (g !== 2'b10 || !seen) begin errors++; $display("FAIL rd_grant got=%b exp=10", g); end
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL rd_req got=%b exp=1", r); end
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL rd_done got=%b exp=10", done); end
        checks++; if (rdata !== 8'h60) begin errors++; $display("FAIL rd_rdata got=%h exp=60", rdata); end
        checks++; if ({drv_sla_addr, drv_sub_addr} !== 16'h7242) begin errors++;
            $display("FAIL rd_addr got=%h exp=7242", {drv_sla_addr, drv_sub_addr}); end
        req_valid = 2'b00; req_rd = 2'b00;
        drv_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit seen; int n;
        req_rd = 2'b00; req_valid = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (drv_wt_req) begin seen = 1'b1; break; end
        end
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n++;
            if (err != 2'b00) break;
        end
        // Counter reaches TIMEOUT_CYC-1 on the TO-th cycle after ISSUE; the
        // registered err pulse follows one cycle later.
        checks++; if (n !== TO + 1 || !seen) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", n, TO + 1); end
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL to_err got=%b exp=01", err); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL to_done got=%b exp=00", done); end
        checks++; if (drv_wt_req !== 1'b0) begin errors++; $display("FAIL to_wt_req got=%b exp=0", drv_wt_req); end
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_release got=%b exp=00", grant); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen; logic [NR-1:0] g; logic r;
        req_rd = 2'b00; req_valid = 2'b10;
        for (int i = 0; i < 2; i++) begin
            drv_serve(1, 1'b1, 8'h00, seen, g, r);
            checks++; if (g !== 2'b10 || !seen) begin errors++; $display("FAIL b2b_grant_%0d got=%b exp=10", i, g); end
            checks++; if (done !== 2'b10) begin errors++; $display("FAIL b2b_done_%0d got=%b exp=10", i, done); end
            drv_idle();
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_fall();
        bit seen; logic [NR-1:0] g; logic r;
        req_rd = 2'b01; req_valid = 2'b01;
        drv_serve(2, 1'b0, 8'hAA, seen, g, r);
        checks++; if (g !== 2'b01 || !seen) begin errors++; $display("FAIL bf_grant got=%b exp=01", g); end
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL bf_err got=%b exp=01", err); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL bf_done got=%b exp=00", done); end
        checks++; if (rdata !== 8'h60) begin errors++; $display("FAIL bf_rdata got=%h exp=60", rdata); end
        req_valid = 2'b00; req_rd = 2'b00;
        drv_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen; logic [NR-1:0] g; logic r; logic [NR-1:0] pulses;
        req_rd = 2'b00; req_valid = 2'b01;
        drv_success = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (drv_wt_req) begin seen = 1'b1; break; end
        end
        drv_busy = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 2'b01 || !seen) begin errors++; $display("FAIL rm_pre_grant got=%b exp=01", grant); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_grant got=%b exp=00", grant); end
        checks++; if (drv_wt_req !== 1'b0) begin errors++; $display("FAIL rm_wt_req got=%b exp=0", drv_wt_req); end
        pulses = '0;
        drv_success = 1'b1;  // would look like a success edge if not in reset
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pulses = pulses | done | err;
        end
        checks++; if (pulses !== 2'b00) begin errors++; $display("FAIL rm_no_pulse got=%b exp=00", pulses); end
        drv_idle();
        rst_n = 1'b1; req_valid = 2'b11;
        drv_serve(1, 1'b1, 8'h00, seen, g, r);
        checks++; if (g !== 2'b01 || !seen) begin errors++; $display("FAIL rm_next_grant got=%b exp=01", g); end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL rm_next_done got=%b exp=01", done); end
        req_valid = 2'b00;
        drv_idle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_timeout();
        test_back_to_back();
        test_busy_fall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
